filtro_cascada: RTL and testbench
=================================

FILTRO_CASCADA -- requirements
Module: filtro_cascada

Interface
REQ-001 SHALL have parameter DECIM, default 14, fractional bits of the fixed-point format.
REQ-002 SHALL have parameter MAGN, default 8, integer bits excluding sign.
REQ-003 SHALL have parameter N, default DECIM+MAGN+1, signed sample/coefficient width.
REQ-004 SHALL have parameter SECTIONS, default 4, number of cascaded biquad sections (1..16).
REQ-005 SHALL have port clock, input, 1, sole clock; all logic rising-edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_data, input, N, signed input sample.
REQ-008 SHALL have port in_valid, input, 1, in_data valid.
REQ-009 SHALL have port in_ready, output, 1, block can accept a sample.
REQ-010 SHALL have port out_data, output, N, signed filtered sample.
REQ-011 SHALL have port out_valid, output, 1, one-cycle pulse, out_data valid.
REQ-012 SHALL have port coef_we, input, 1, coefficient write strobe.
REQ-013 SHALL have port coef_addr, input, clog2(5*SECTIONS), coefficient index = 5*section + k, k: 0=b0,1=b1,2=b2,3=a1,4=a2.
REQ-014 SHALL have port coef_data, input, N, signed coefficient.
REQ-015 SHALL have port clear, input, 1, synchronous zeroing of all section state.

Function
REQ-016 Each section SHALL compute transposed direct form II: y=b0*x+s1; s1'=b1*x+a1*y+s2; s2'=b2*x+a2*y (a-coefficients stored pre-negated, added).
REQ-017 Section i output SHALL be section i+1 input; out_data SHALL be last section output.
REQ-018 Products SHALL be full 2N-bit, rescaled by arithmetic right shift DECIM, then reduced to N bits per REQ-033/034.
REQ-019 One shared multiplier-adder SHALL be time-multiplexed: exactly 5 cycles per section, order b0, b1, a1, b2, a2.
REQ-020 FSM states: IDLE, CALC, OUT.
REQ-021 IDLE: in_ready=1; in_valid=1 captures in_data, section=0, step=0, go CALC.
REQ-022 CALC: in_ready=0; step 0..4 increments each cycle; after step 4 of section SECTIONS-1 go OUT, else section+1, step 0.
REQ-023 OUT: out_data updated, out_valid=1 for exactly one cycle, return IDLE.
REQ-024 Latency: accept cycle T -> out_valid at T+5*SECTIONS+1; throughput one sample per 5*SECTIONS+2 cycles.
REQ-025 in_valid while in_ready=0 SHALL be ignored (no sample lost silently: source must hold until in_ready).
REQ-026 coef_we SHALL write only in IDLE; writes in CALC/OUT ignored; coef_addr >= 5*SECTIONS ignored.
REQ-027 coef_we and in_valid in same IDLE cycle: coefficient write completes first; captured sample uses new coefficient.
REQ-028 clear in IDLE zeroes s1/s2 of every section; clear in CALC/OUT ignored.
REQ-029 out_data SHALL hold its value until next OUT.

Reset
REQ-030 reset low SHALL asynchronously force state IDLE, in_ready=1, out_valid=0, out_data=0, all s1/s2=0, counters=0.
REQ-031 Reset SHALL set all coefficients to 0 except each b0 = 1.0 (1<<DECIM), i.e. pass-through.
REQ-032 Reset asserted mid-CALC SHALL abort the sample with no out_valid.

Configuration
REQ-033 With FILTRO_SAT_EN defined, every rescaled product and sum SHALL saturate to [-(2^(N-1)), 2^(N-1)-1].
REQ-034 Without FILTRO_SAT_EN, results SHALL wrap (truncate to N LSBs, two's complement).

Structure
REQ-035 Package filtro_pkg SHALL hold state enum (IDLE/CALC/OUT), step encoding constants, and default DECIM/MAGN.
REQ-036 One sub-module mac_punto_fijo SHALL implement multiply, DECIM rescale, add and saturate/wrap, combinational.
REQ-037 Coefficients and state SHALL be register arrays indexed by section.

Verification
REQ-038 After reset, in_data=0x001000 -> out_data=0x001000 at T+21 (SECTIONS=4), pass-through.
REQ-039 Section0 b0=0x2000 (0.5), others reset; impulse 0x004000 then zeros -> outputs 0x002000, 0, 0.
REQ-040 Section0 b0=0x4000, a1=0x2000 (pole 0.5); impulse 0x004000 -> outputs 0x004000, 0x002000, 0x001000, 0x000800.
REQ-041 b0=0x3FFFFF on all sections, input 0x3FFFFF: SAT_EN -> 0x3FFFFF; without -> wrapped value matching model.
REQ-042 in_valid held during CALC, coef_we during CALC -> single output, coefficient unchanged.
REQ-043 reset pulse mid-CALC -> no out_valid, state zeros; clear in IDLE after nonzero history -> next impulse response matches fresh start.

Source files
------------

// File: rtl/filtro_pkg.sv
// Shared types and constants for the filtro_cascada biquad cascade.
package filtro_pkg;

  localparam int DECIM_DEF     = 14;
  localparam int MAGN_DEF      = 8;
  localparam int COEFS_PER_SEC = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_e;

  // MAC step order inside one section
  localparam logic [2:0] STEP_B0 = 3'd0;
  localparam logic [2:0] STEP_B1 = 3'd1;
  localparam logic [2:0] STEP_A1 = 3'd2;
  localparam logic [2:0] STEP_B2 = 3'd3;
  localparam logic [2:0] STEP_A2 = 3'd4;

  // coefficient slot inside a section's address block (address = 5*section + k)
  localparam int K_B0 = 0;
  localparam int K_B1 = 1;
  localparam int K_B2 = 2;
  localparam int K_A1 = 3;
  localparam int K_A2 = 4;

endpackage

// File: rtl/filtro_cascada_mac.sv
// Shared fixed-point multiply-accumulate, combinational: reduce(reduce((coef*operand)>>>DECIM) + acc).
// FILTRO_SAT_EN selects saturation of product and sum; otherwise both wrap to N bits.
module mac_punto_fijo
  import filtro_pkg::*;
#(
  parameter int N     = DECIM_DEF + MAGN_DEF + 1,
  parameter int DECIM = DECIM_DEF
) (
  input  logic signed [N-1:0] coef,
  input  logic signed [N-1:0] operand,
  input  logic signed [N-1:0] acc,
  output logic signed [N-1:0] result
);

  localparam int W2 = 2 * N;

  logic signed [W2-1:0] prod;
  logic signed [N-1:0]  prod_red;

`ifdef FILTRO_SAT_EN
  localparam logic signed [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

  logic signed [W2-1:0] prod_sh;
  logic signed [N:0]    sum;

  always_comb begin
    prod    = W2'(coef) * W2'(operand);
    prod_sh = prod >>> DECIM;
    // out of range when the bits above the N-bit sign do not all match it
    if (prod_sh[W2-1:N-1] != {(N+1){prod_sh[W2-1]}}) begin
      prod_red = prod_sh[W2-1] ? SAT_MIN : SAT_MAX;
    end else begin
      prod_red = prod_sh[N-1:0];
    end
    sum = {acc[N-1], acc} + {prod_red[N-1], prod_red};
    if (sum[N] != sum[N-1]) begin
      result = sum[N] ? SAT_MIN : SAT_MAX;
    end else begin
      result = sum[N-1:0];
    end
  end
`else
  always_comb begin
    prod     = W2'(coef) * W2'(operand);
    prod_red = N'(prod >>> DECIM);
    result   = acc + prod_red;
  end
`endif

endmodule

// File: rtl/filtro_cascada.sv
// Cascade of SECTIONS transposed-DF2 biquads sharing one MAC, 5 cycles per section.
// Define FILTRO_SAT_EN for saturating arithmetic; default build wraps.
//   state | meaning
//   IDLE  | ready; coefficient writes, clear and sample capture allowed
//   CALC  | stepping b0,b1,a1,b2,a2 through every section
//   OUT   | out_data freshly loaded, out_valid pulse
module filtro_cascada
  import filtro_pkg::*;
#(
  parameter int DECIM    = DECIM_DEF,
  parameter int MAGN     = MAGN_DEF,
  parameter int N        = DECIM + MAGN + 1,
  parameter int SECTIONS = 4
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic signed [N-1:0]                   in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic signed [N-1:0]                   out_data,
  output logic                                  out_valid,
  input  logic                                  coef_we,
  input  logic [$clog2(5*SECTIONS)-1:0]         coef_addr,
  input  logic signed [N-1:0]                   coef_data,
  input  logic                                  clear
);

  localparam int NCOEF = COEFS_PER_SEC * SECTIONS;
  localparam int AW    = $clog2(NCOEF);
  localparam int SW    = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
  localparam logic [SW-1:0]       LAST_SEC = SW'(SECTIONS - 1);
  localparam logic signed [N-1:0] UNITY    = N'(64'd1 << DECIM);

  state_e              state_q, state_d;
  logic [SW-1:0]       sec_q, sec_d;
  logic [2:0]          step_q, step_d;
  logic signed [N-1:0] x_q, x_d;
  logic signed [N-1:0] y_q, y_d;
  logic signed [N-1:0] t_q, t_d;
  logic signed [N-1:0] out_q, out_d;
  logic signed [N-1:0] coef_q [SECTIONS][COEFS_PER_SEC];
  logic signed [N-1:0] coef_d [SECTIONS][COEFS_PER_SEC];
  logic signed [N-1:0] s1_q [SECTIONS];
  logic signed [N-1:0] s1_d [SECTIONS];
  logic signed [N-1:0] s2_q [SECTIONS];
  logic signed [N-1:0] s2_d [SECTIONS];

  logic signed [N-1:0] mac_coef, mac_operand, mac_acc, mac_result;
  logic                last_step;

  assign last_step = (step_q == STEP_A2);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    if (last_step && (sec_q == LAST_SEC)) state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == OUT);
  end

  assign out_data = out_q;

  // operand routing: x feeds the b terms, y the a terms, t carries partial sums
  always_comb begin
    mac_coef    = '0;
    mac_operand = x_q;
    mac_acc     = '0;
    case (step_q)
      STEP_B0: begin
        mac_coef = coef_q[sec_q][K_B0];
        mac_acc  = s1_q[sec_q];
      end
      STEP_B1: begin
        mac_coef = coef_q[sec_q][K_B1];
        mac_acc  = s2_q[sec_q];
      end
      STEP_A1: begin
        mac_coef    = coef_q[sec_q][K_A1];
        mac_operand = y_q;
        mac_acc     = t_q;
      end
      STEP_B2: begin
        mac_coef = coef_q[sec_q][K_B2];
      end
      STEP_A2: begin
        mac_coef    = coef_q[sec_q][K_A2];
        mac_operand = y_q;
        mac_acc     = t_q;
      end
      default: ;
    endcase
  end

  mac_punto_fijo #(
    .N     (N),
    .DECIM (DECIM)
  ) u_mac (
    .coef    (mac_coef),
    .operand (mac_operand),
    .acc     (mac_acc),
    .result  (mac_result)
  );

  always_comb begin
    sec_d  = sec_q;
    step_d = step_q;
    x_d    = x_q;
    y_d    = y_q;
    t_d    = t_q;
    out_d  = out_q;
    coef_d = coef_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          for (int s = 0; s < SECTIONS; s++) begin
            s1_d[s] = '0;
            s2_d[s] = '0;
          end
        end
        // out-of-range addresses match no slot and are dropped
        if (coef_we) begin
          for (int s = 0; s < SECTIONS; s++) begin
            for (int k = 0; k < COEFS_PER_SEC; k++) begin
              if (coef_addr == AW'(COEFS_PER_SEC * s + k)) coef_d[s][k] = coef_data;
            end
          end
        end
        if (in_valid) begin
          x_d    = in_data;
          sec_d  = '0;
          step_d = STEP_B0;
        end
      end
      CALC: begin
        case (step_q)
          STEP_B0: y_d = mac_result;
          STEP_B1: t_d = mac_result;
          STEP_A1: s1_d[sec_q] = mac_result;
          STEP_B2: t_d = mac_result;
          STEP_A2: begin
            s2_d[sec_q] = mac_result;
            x_d         = y_q;
            if (sec_q == LAST_SEC) out_d = y_q;
          end
          default: ;
        endcase
        if (last_step) begin
          step_d = STEP_B0;
          sec_d  = (sec_q == LAST_SEC) ? '0 : sec_q + SW'(1);
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sec_q  <= '0;
      step_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      t_q    <= '0;
      out_q  <= '0;
      for (int s = 0; s < SECTIONS; s++) begin
        s1_q[s] <= '0;
        s2_q[s] <= '0;
        for (int k = 0; k < COEFS_PER_SEC; k++) coef_q[s][k] <= '0;
        coef_q[s][K_B0] <= UNITY;
      end
    end else begin
      sec_q  <= sec_d;
      step_q <= step_d;
      x_q    <= x_d;
      y_q    <= y_d;
      t_q    <= t_d;
      out_q  <= out_d;
      coef_q <= coef_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
    end
  end

endmodule

// File: tb/tb_filtro_cascada.sv
// Self-checking bench for filtro_cascada: directed and randomized samples compared
// against a behavioural model of the biquad cascade (wrap or saturate per FILTRO_SAT_EN).
module tb_filtro_cascada;

  localparam int DECIM = 14;
  localparam int N     = 23;
  localparam int S     = 4;
  localparam int NC    = 5 * S;
  localparam int AW    = 5;
  localparam int LAT   = 5 * S + 1;
  localparam longint MAXV = (64'sd1 <<< (N - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (N - 1));

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic signed [N-1:0] in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [N-1:0] out_data;
  logic                out_valid;
  logic                coef_we = 1'b0;
  logic [AW-1:0]       coef_addr = '0;
  logic signed [N-1:0] coef_data = '0;
  logic                clear = 1'b0;

  int checks = 0;
  int failures = 0;

  longint mc [NC];
  longint ms1 [S];
  longint ms2 [S];

  filtro_cascada dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .clear     (clear)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic longint red(input longint v);
`ifdef FILTRO_SAT_EN
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
`else
    longint r;
    r = v & ((64'sd1 <<< N) - 1);
    if (r > MAXV) r = r - (64'sd1 <<< N);
    return r;
`endif
  endfunction

  function automatic longint mulr(input longint c, input longint x);
    return red((c * x) >>> DECIM);
  endfunction

  task automatic model_run(input longint x_in, output longint y_out);
    longint x, y, t;
    x = x_in;
    for (int s = 0; s < S; s++) begin
      y      = red(mulr(mc[5*s+0], x) + ms1[s]);
      t      = red(mulr(mc[5*s+1], x) + ms2[s]);
      ms1[s] = red(mulr(mc[5*s+3], y) + t);
      ms2[s] = red(mulr(mc[5*s+2], x) + mulr(mc[5*s+4], y));
      x      = y;
    end
    y_out = x;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) mc[i] = (i % 5 == 0) ? 64'sd16384 : 64'sd0;
    for (int s = 0; s < S; s++) begin
      ms1[s] = 0;
      ms2[s] = 0;
    end
  endtask

  // ---------------- drivers (called at a negedge with DUT idle) ----------------
  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; coef_we = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    model_reset();
    @(negedge clock);
  endtask

  task automatic write_coef(input int addr, input longint data);
    coef_we = 1'b1; coef_addr = AW'(addr); coef_data = N'(data);
    @(negedge clock);
    coef_we = 1'b0;
    if (addr < NC) mc[addr] = data;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    for (int s = 0; s < S; s++) begin
      ms1[s] = 0;
      ms2[s] = 0;
    end
  endtask

  task automatic send(input longint x, input bit with_coef, input int addr, input longint cdata,
                      output logic signed [N-1:0] got, output int lat, output bit busy_ok);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 100) begin
      @(negedge clock);
      w++;
    end
    in_data = N'(x); in_valid = 1'b1;
    if (with_coef) begin
      coef_we = 1'b1; coef_addr = AW'(addr); coef_data = N'(cdata);
    end
    @(negedge clock);
    in_valid = 1'b0; coef_we = 1'b0;
    lat = -1; busy_ok = 1'b1; got = '0;
    for (int k = 1; k <= LAT + 10; k++) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      if (out_valid === 1'b1) begin
        lat = k;
        got = out_data;
        break;
      end
      @(negedge clock);
    end
    if (lat > 0) begin
      @(negedge clock);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %h want 0", out_data); end
  endtask

  task automatic test_passthrough();
    logic signed [N-1:0] got, r;
    longint e, x;
    int lat;
    bit bok;
    model_run(64'sh1000, e);
    send(64'sh1000, 1'b0, 0, 0, got, lat, bok);
    checks++;
    if (got !== 23'h001000) begin failures++; $display("FAIL pass_const: got %h want 001000", got); end
    checks++;
    if (lat != LAT) begin failures++; $display("FAIL pass_latency: got %0d want %0d", lat, LAT); end
    checks++;
    if (!bok) begin failures++; $display("FAIL pass_handshake: got 0 want 1"); end
    for (int i = 0; i < 5; i++) begin
      r = N'($urandom);
      x = longint'(r);
      model_run(x, e);
      send(x, 1'b0, 0, 0, got, lat, bok);
      checks++;
      if (got !== N'(e) || lat != LAT) begin
        failures++; $display("FAIL pass_rand[%0d]: got %h lat %0d want %h lat %0d", i, got, lat, N'(e), LAT);
      end
    end
  endtask

  task automatic test_scale();
    logic signed [N-1:0] got;
    logic signed [N-1:0] want [3];
    longint xs [3];
    longint e;
    int lat;
    bit bok;
    want[0] = 23'h002000; want[1] = '0; want[2] = '0;
    xs[0] = 64'sh4000; xs[1] = 0; xs[2] = 0;
    write_coef(0, 64'sh2000);
    for (int i = 0; i < 3; i++) begin
      model_run(xs[i], e);
      send(xs[i], 1'b0, 0, 0, got, lat, bok);
      checks++;
      if (got !== want[i]) begin failures++; $display("FAIL scale[%0d]: got %h want %h", i, got, want[i]); end
    end
    write_coef(0, 64'sh4000);
  endtask

  task automatic test_pole();
    logic signed [N-1:0] got;
    logic signed [N-1:0] want [4];
    longint e;
    int lat;
    bit bok;
    want[0] = 23'h004000; want[1] = 23'h002000; want[2] = 23'h001000; want[3] = 23'h000800;
    write_coef(3, 64'sh2000);
    for (int i = 0; i < 4; i++) begin
      model_run((i == 0) ? 64'sh4000 : 64'sd0, e);
      send((i == 0) ? 64'sh4000 : 64'sd0, 1'b0, 0, 0, got, lat, bok);
      checks++;
      if (got !== want[i]) begin failures++; $display("FAIL pole[%0d]: got %h want %h", i, got, want[i]); end
    end
  endtask

  task automatic test_clear();
    logic signed [N-1:0] got;
    longint e;
    int lat;
    bit bok;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      model_run((i == 0) ? 64'sh4000 : 64'sd0, e);
      send((i == 0) ? 64'sh4000 : 64'sd0, 1'b0, 0, 0, got, lat, bok);
      checks++;
      if (got !== N'(e)) begin failures++; $display("FAIL clear_resp[%0d]: got %h want %h", i, got, N'(e)); end
    end
  endtask

  task automatic test_busy();
    logic signed [N-1:0] got, held;
    longint e;
    int lat, pulses;
    bit bok;
    do_clear();
    model_run(64'sh4000, e);
    in_data = 23'h004000; in_valid = 1'b1;
    @(negedge clock);
    pulses = 0; held = '0;
    for (int k = 0; k < LAT + 30; k++) begin
      if (out_valid === 1'b1) begin
        pulses++;
        held = out_data;
        in_valid = 1'b0; coef_we = 1'b0; clear = 1'b0;
      end else if (pulses == 0) begin
        in_valid = 1'b1; in_data = N'($urandom);
        coef_we = 1'b1; coef_addr = '0; coef_data = 23'h001234; clear = 1'b1;
      end
      @(negedge clock);
    end
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL busy_pulses: got %0d want 1", pulses); end
    checks++;
    if (held !== N'(e)) begin failures++; $display("FAIL busy_data: got %h want %h", held, N'(e)); end
    checks++;
    if (out_data !== N'(e)) begin failures++; $display("FAIL busy_hold: got %h want %h", out_data, N'(e)); end
    write_coef(20, 64'sh7777);
    write_coef(31, 64'sh5555);
    model_run(64'sh1000, e);
    send(64'sh1000, 1'b0, 0, 0, got, lat, bok);
    checks++;
    if (got !== N'(e)) begin failures++; $display("FAIL busy_after: got %h want %h", got, N'(e)); end
  endtask

  task automatic test_same_cycle();
    logic signed [N-1:0] got;
    longint e;
    int lat;
    bit bok;
    mc[0] = 64'sh2000;
    model_run(64'sh4000, e);
    send(64'sh4000, 1'b1, 0, 64'sh2000, got, lat, bok);
    checks++;
    if (got !== N'(e) || lat != LAT) begin
      failures++; $display("FAIL same_cycle: got %h lat %0d want %h lat %0d", got, lat, N'(e), LAT);
    end
  endtask

  task automatic test_reset_mid();
    logic signed [N-1:0] got;
    longint e;
    int lat, pulses;
    bit bok;
    in_data = 23'h002345; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (7) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      failures++; $display("FAIL reset_mid_async: got ready %b valid %b data %h want 1 0 0", in_ready, out_valid, out_data);
    end
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    pulses = 0;
    for (int k = 0; k < LAT + 10; k++) begin
      if (out_valid === 1'b1) pulses++;
      @(negedge clock);
    end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL reset_mid_no_out: got %0d pulses want 0", pulses); end
    model_run(64'sh1000, e);
    send(64'sh1000, 1'b0, 0, 0, got, lat, bok);
    checks++;
    if (got !== N'(e) || lat != LAT || !bok) begin
      failures++; $display("FAIL reset_mid_after: got %h lat %0d want %h lat %0d", got, lat, N'(e), LAT);
    end
  endtask

  task automatic test_random();
    logic signed [N-1:0] got, r;
    longint e, x, c;
    int lat;
    bit bok;
    do_reset();
    for (int a = 0; a < NC; a++) begin
      c = longint'($urandom_range(0, 24575)) - 64'sd12288;
      write_coef(a, c);
    end
    for (int i = 0; i < 12; i++) begin
      r = N'($urandom);
      x = longint'(r);
      model_run(x, e);
      send(x, 1'b0, 0, 0, got, lat, bok);
      checks++;
      if (got !== N'(e) || lat != LAT || !bok) begin
        failures++; $display("FAIL random[%0d]: got %h lat %0d want %h lat %0d", i, got, lat, N'(e), LAT);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [N-1:0] got;
    longint e;
    int lat;
    bit bok;
    do_reset();
    for (int s = 0; s < S; s++) write_coef(5 * s, 64'sh3FFFFF);
    model_run(64'sh3FFFFF, e);
    send(64'sh3FFFFF, 1'b0, 0, 0, got, lat, bok);
    checks++;
    if (got !== N'(e)) begin failures++; $display("FAIL sat_pos: got %h want %h", got, N'(e)); end
    model_run(MINV, e);
    send(MINV, 1'b0, 0, 0, got, lat, bok);
    checks++;
    if (got !== N'(e)) begin failures++; $display("FAIL sat_neg: got %h want %h", got, N'(e)); end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    test_reset();
    reset = 1'b1;
    @(negedge clock);
    test_reset();
    test_passthrough();
    test_scale();
    test_pole();
    test_clear();
    test_busy();
    test_same_cycle();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
